// File: rtl/csam_pkg.sv
// Shared widths and Baugh-Wooley correction constants for the 16x12 signed carry-save multiplier.
// Constant-only package; no latency or flow control.
package csam_pkg;

    localparam int A_W = 16;
    localparam int B_W = 12;
    localparam int P_W = 28;

    // Columns that receive the constant 1s folding in the sign-row negations
    localparam int BW_COL_B = B_W - 1;
    localparam int BW_COL_A = A_W - 1;
    localparam int BW_COL_P = P_W - 1;

    localparam logic [P_W-1:0] BW_CONST = (P_W'(1) << BW_COL_B)
                                        | (P_W'(1) << BW_COL_A)
                                        | (P_W'(1) << BW_COL_P);

endpackage

// File: rtl/csam_if.sv
// Operand/product bundle for csam_mult: a, b in; sum (comb) and sum_q (1 cycle) out.
// No handshake: operands are accepted every cycle, there is no backpressure.
interface csam_if;
    import csam_pkg::*;

    logic [A_W-1:0] a;
    logic [B_W-1:0] b;
    logic [P_W-1:0] sum;
    logic [P_W-1:0] sum_q;

    modport master (output a, output b, input sum, input sum_q);
    modport slave  (input a, input b, output sum, output sum_q);

endinterface

// File: rtl/csam_fa.sv
// One-bit full adder cell used for both the carry-save grid and the final ripple row.
// Purely combinational; no flow control.
module csam_fa (
    input  logic i_a,
    input  logic i_b,
    input  logic i_cin,
    output logic o_s,
    output logic o_cout
);

    assign o_s    = i_a ^ i_b ^ i_cin;
    assign o_cout = (i_a & i_b) | (i_a & i_cin) | (i_b & i_cin);

endmodule

// File: rtl/csam_mult.sv
// Signed 16x12 modified Baugh-Wooley carry-save array multiplier, full 28-bit product.
// Latency: sum combinational, sum_q one cycle; no backpressure, new operands every cycle.
module csam_mult
    import csam_pkg::*;
(
    input  logic    clk,
    input  logic    reset,
    csam_if.slave   bus
);

    logic [B_W-1:0][A_W-1:0] w_pp;
    logic [B_W-1:0][P_W-1:0] w_row;
    logic [B_W-1:0][P_W-1:0] w_s;
    logic [B_W-1:0][P_W-1:0] w_c;
    logic [B_W-1:1][P_W-2:0] w_maj;
    logic [P_W-1:0]          w_rc;
    logic [P_W-1:0]          w_sum;
    logic [P_W-1:0]          r_sum_q;

    genvar gi, gj, gk;

    // Sign-row and sign-column partial products are inverted, except the shared corner bit
    for (gj = 0; gj < B_W; gj++) begin : g_pp_row
        for (gi = 0; gi < A_W; gi++) begin : g_pp_bit
            localparam bit FLIP = (gi == A_W - 1) ^ (gj == B_W - 1);
            assign w_pp[gj][gi] = (bus.a[gi] & bus.b[gj]) ^ FLIP;
        end
        assign w_row[gj] = P_W'(w_pp[gj]) << gj;
    end

    assign w_s[0] = w_row[0];
    assign w_c[0] = BW_CONST;

    for (gj = 1; gj < B_W; gj++) begin : g_csa_row
        for (gk = 0; gk < P_W - 1; gk++) begin : g_csa_bit
            csam_fa u_fa (
                .i_a    (w_s[gj-1][gk]),
                .i_b    (w_c[gj-1][gk]),
                .i_cin  (w_row[gj][gk]),
                .o_s    (w_s[gj][gk]),
                .o_cout (w_maj[gj][gk])
            );
        end
        // Carry out of the top column falls outside the 28-bit modulus
        assign w_s[gj][P_W-1] = w_s[gj-1][P_W-1] ^ w_c[gj-1][P_W-1] ^ w_row[gj][P_W-1];
        assign w_c[gj]        = {w_maj[gj], 1'b0};
    end

    assign w_rc[0] = 1'b0;

    for (gk = 0; gk < P_W - 1; gk++) begin : g_cpa
        csam_fa u_fa (
            .i_a    (w_s[B_W-1][gk]),
            .i_b    (w_c[B_W-1][gk]),
            .i_cin  (w_rc[gk]),
            .o_s    (w_sum[gk]),
            .o_cout (w_rc[gk+1])
        );
    end
    assign w_sum[P_W-1] = w_s[B_W-1][P_W-1] ^ w_c[B_W-1][P_W-1] ^ w_rc[P_W-1];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sum_q <= '0;
        end else begin
            r_sum_q <= w_sum;
        end
    end

    assign bus.sum   = w_sum;
    assign bus.sum_q = r_sum_q;

endmodule

// File: tb/tb_csam_mult.sv
// Scoreboard bench for csam_mult: driver queues expected sum/sum_q per cycle, monitor checks at negedge.
module tb_csam_mult;

    logic clk;
    logic reset;

    csam_if u_if ();

    csam_mult u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (u_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [27:0] sum;
        logic [27:0] q;
        bit          chk_q;
        int          id;
    } exp_t;

    exp_t sb [$];

    int n_cmp = 0;
    int n_err = 0;
    int n_vec = 0;

    logic [27:0] prev_exp;
    logic        prev_rst;
    bit          prev_vld;

    // One vector per cycle; sum_q expectation comes from what the previous edge sampled
    task automatic drive(input logic [15:0] av, input logic [11:0] bv,
                         input logic rv, input logic [27:0] ex);
        exp_t e;
        @(posedge clk);
        #1;
        u_if.a  = av;
        u_if.b  = bv;
        reset   = rv;
        e.sum   = ex;
        e.q     = prev_rst ? 28'h0 : prev_exp;
        e.chk_q = prev_vld;
        e.id    = n_vec;
        sb.push_back(e);
        prev_exp = ex;
        prev_rst = rv;
        prev_vld = 1'b1;
        n_vec++;
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            n_cmp++;
            if (u_if.sum !== e.sum) begin
                n_err++;
                $display("FAIL sum vec%0d a=%h b=%h got=%h exp=%h",
                         e.id, u_if.a, u_if.b, u_if.sum, e.sum);
            end
            if (e.chk_q) begin
                n_cmp++;
                if (u_if.sum_q !== e.q) begin
                    n_err++;
                    $display("FAIL sum_q vec%0d got=%h exp=%h", e.id, u_if.sum_q, e.q);
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        logic [15:0] ra;
        logic [11:0] rb;
        logic signed [27:0] p;

        reset    = 1'b1;
        u_if.a   = 16'h0;
        u_if.b   = 12'h0;
        prev_exp = 28'h0;
        prev_rst = 1'b1;
        prev_vld = 1'b1;

        // Reset state, then directed corners
        drive(16'h0000, 12'h000, 1'b1, 28'h0000000);
        drive(16'h7FFF, 12'h7FF, 1'b0, 28'h3FF7801);
        drive(16'h8000, 12'h800, 1'b0, 28'h4000000);
        drive(16'h8000, 12'h7FF, 1'b0, 28'hC008000);
        drive(16'h0003, 12'hFFE, 1'b0, 28'hFFFFFFA);
        drive(16'hFFFF, 12'hFFF, 1'b0, 28'h0000001);
        drive(16'h1234, 12'h000, 1'b0, 28'h0000000);
        drive(16'h0001, 12'h800, 1'b0, 28'hFFFF800);
        drive(16'h7FFF, 12'h800, 1'b0, 28'hC000800);
        drive(16'h8000, 12'hFFF, 1'b0, 28'h0008000);

        // Mid-stream reset: sum keeps tracking, sum_q held at zero
        drive(16'h7FFF, 12'h7FF, 1'b1, 28'h3FF7801);
        drive(16'h7FFF, 12'h7FF, 1'b1, 28'h3FF7801);
        drive(16'h7FFF, 12'h7FF, 1'b0, 28'h3FF7801);
        drive(16'h0001, 12'h800, 1'b0, 28'hFFFF800);
        drive(16'h0002, 12'h003, 1'b0, 28'h0000006);

        for (int k = 0; k < 10000; k++) begin
            ra = 16'($urandom);
            rb = 12'($urandom);
            p  = $signed(ra) * $signed(rb);
            drive(ra, rb, 1'b0, p);
        end

        @(negedge clk);
        @(negedge clk);
        #1;
        n_cmp++;
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard_drain left=%0d exp=0", sb.size());
        end

        $display("vectors applied: %0d", n_vec);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
